// File: rtl/riscv_mstage.sv
// Memory-access stage: one outstanding req/ack data-memory transaction per instruction,
// byte-lane steering for stores and aligned, extended load data for write-back.
module riscv_mstage #(
   parameter int width = 64
) (
   input  logic             i_riscv_mstage_clk,
   input  logic             i_riscv_mstage_rst,
   input  logic             i_riscv_mstage_valid,
   input  logic             i_riscv_mstage_memread,
   input  logic             i_riscv_mstage_memwrite,
   input  logic [2:0]       i_riscv_mstage_funct3,
   input  logic [width-1:0] i_riscv_mstage_addr,
   input  logic [width-1:0] i_riscv_mstage_wdata,
   input  logic             i_riscv_mstage_flush,
   output logic             o_riscv_mstage_dmreq,
   output logic             o_riscv_mstage_dmwe,
   output logic [width-1:0] o_riscv_mstage_dmaddr,
   output logic [width-1:0] o_riscv_mstage_dmwdata,
   output logic [7:0]       o_riscv_mstage_dmmask,
   input  logic             i_riscv_mstage_dmack,
   input  logic [width-1:0] i_riscv_mstage_dmrdata,
   output logic             o_riscv_mstage_stall,
   output logic [width-1:0] o_riscv_mstage_rdata,
   output logic             o_riscv_mstage_rvalid,
   output logic             o_riscv_mstage_misaligned,
   output logic [width-1:0] o_riscv_mstage_badaddr
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [2:0]       f3;
   logic [2:0]       off_q;
   logic [2:0]       f3_q;
   logic             killed;
   logic             is_wr;
   logic             access;
   logic             mis;
   logic             start;
   logic [7:0]       mask;
   logic [width-1:0] shifted;
   logic [width-1:0] ext;

   // 111 has no encoding of its own; it behaves as a doubleword access
   assign f3     = (i_riscv_mstage_funct3 == 3'b111) ? 3'b011 : i_riscv_mstage_funct3;
   assign is_wr  = i_riscv_mstage_memwrite & ~i_riscv_mstage_memread;
   assign access = (state == IDLE) & i_riscv_mstage_valid & ~i_riscv_mstage_flush &
                   (i_riscv_mstage_memread | i_riscv_mstage_memwrite);

   always_comb begin
      mis  = 1'b0;
      mask = 8'hFF;
      unique case (f3[1:0])
         2'b00: begin mis = 1'b0;                          mask = 8'h01 << i_riscv_mstage_addr[2:0]; end
         2'b01: begin mis = i_riscv_mstage_addr[0];        mask = 8'h03 << i_riscv_mstage_addr[2:0]; end
         2'b10: begin mis = |i_riscv_mstage_addr[1:0];     mask = 8'h0F << i_riscv_mstage_addr[2:0]; end
         2'b11: begin mis = |i_riscv_mstage_addr[2:0];     mask = 8'hFF; end
      endcase
   end

   assign start                     = access & ~mis;
   assign o_riscv_mstage_misaligned = access & mis;
   assign o_riscv_mstage_badaddr    = o_riscv_mstage_misaligned ? i_riscv_mstage_addr : '0;
   assign o_riscv_mstage_stall      = start | (state == BUSY);

   // Load alignment and extension use the offset/size captured at accept time
   assign shifted = i_riscv_mstage_dmrdata >> {off_q, 3'b000};

   always_comb begin
      ext = shifted;
      unique case (f3_q[1:0])
         2'b00: ext = {{(width-8){~f3_q[2] & shifted[7]}},   shifted[7:0]};
         2'b01: ext = {{(width-16){~f3_q[2] & shifted[15]}}, shifted[15:0]};
         2'b10: ext = {{(width-32){~f3_q[2] & shifted[31]}}, shifted[31:0]};
         2'b11: ext = shifted;
      endcase
   end

   always_ff @(posedge i_riscv_mstage_clk or negedge i_riscv_mstage_rst) begin
      if (!i_riscv_mstage_rst) begin
         state                  <= IDLE;
         o_riscv_mstage_dmreq   <= 1'b0;
         o_riscv_mstage_dmwe    <= 1'b0;
         o_riscv_mstage_dmaddr  <= '0;
         o_riscv_mstage_dmwdata <= '0;
         o_riscv_mstage_dmmask  <= 8'h00;
         o_riscv_mstage_rdata   <= '0;
         o_riscv_mstage_rvalid  <= 1'b0;
         off_q                  <= 3'b000;
         f3_q                   <= 3'b000;
         killed                 <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               o_riscv_mstage_rvalid <= 1'b0;
               killed                <= 1'b0;
               if (start) begin
                  state                  <= BUSY;
                  o_riscv_mstage_dmreq   <= 1'b1;
                  o_riscv_mstage_dmwe    <= is_wr;
                  o_riscv_mstage_dmaddr  <= {i_riscv_mstage_addr[width-1:3], 3'b000};
                  o_riscv_mstage_dmwdata <= i_riscv_mstage_wdata << {i_riscv_mstage_addr[2:0], 3'b000};
                  o_riscv_mstage_dmmask  <= mask;
                  off_q                  <= i_riscv_mstage_addr[2:0];
                  f3_q                   <= f3;
               end
            end
            BUSY: begin
               // A flush cannot withdraw the request; the result is just discarded
               if (i_riscv_mstage_flush) killed <= 1'b1;
               if (i_riscv_mstage_dmack) begin
                  o_riscv_mstage_dmreq <= 1'b0;
                  if (killed | i_riscv_mstage_flush) begin
                     state  <= IDLE;
                     killed <= 1'b0;
                  end else begin
                     state <= DONE;
                     if (!o_riscv_mstage_dmwe) begin
                        o_riscv_mstage_rdata  <= ext;
                        o_riscv_mstage_rvalid <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               o_riscv_mstage_rvalid <= 1'b0;
               state                 <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mstage.sv
// Directed bench for riscv_mstage: loads, stores, misalignment, flush in flight, reset mid-access.
module tb_riscv_mstage;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid, memread, memwrite, flush, dmack;
   logic [2:0]   funct3;
   logic [W-1:0] addr, wdata, dmrdata;
   logic         dmreq, dmwe, stall, rvalid, misaligned;
   logic [W-1:0] dmaddr, dmwdata, rdata, badaddr;
   logic [7:0]   dmmask;

   int checks = 0;
   int errors = 0;

   riscv_mstage #(.width(W)) dut (
      .i_riscv_mstage_clk(clk),
      .i_riscv_mstage_rst(rst_n),
      .i_riscv_mstage_valid(valid),
      .i_riscv_mstage_memread(memread),
      .i_riscv_mstage_memwrite(memwrite),
      .i_riscv_mstage_funct3(funct3),
      .i_riscv_mstage_addr(addr),
      .i_riscv_mstage_wdata(wdata),
      .i_riscv_mstage_flush(flush),
      .o_riscv_mstage_dmreq(dmreq),
      .o_riscv_mstage_dmwe(dmwe),
      .o_riscv_mstage_dmaddr(dmaddr),
      .o_riscv_mstage_dmwdata(dmwdata),
      .o_riscv_mstage_dmmask(dmmask),
      .i_riscv_mstage_dmack(dmack),
      .i_riscv_mstage_dmrdata(dmrdata),
      .o_riscv_mstage_stall(stall),
      .o_riscv_mstage_rdata(rdata),
      .o_riscv_mstage_rvalid(rvalid),
      .o_riscv_mstage_misaligned(misaligned),
      .o_riscv_mstage_badaddr(badaddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; checks follow a further 1ns settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] wd);
      valid = 1'b1; memread = rd; memwrite = wr; funct3 = f; addr = a; wdata = wd;
   endtask

   task automatic idle_in();
      valid = 1'b0; memread = 1'b0; memwrite = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; idle_in(); dmack = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; dmrdata = '0;
      #12;
      chk("rst_dmreq", {63'd0, dmreq}, 64'd0);
      chk("rst_dmaddr", dmaddr, 64'd0);
      chk("rst_dmmask", {56'd0, dmmask}, 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      step(); rst_n = 1'b1;

      // lb 0x1003, ack in the third BUSY cycle
      step(); issue(1, 0, 3'b000, 64'h1003, 64'd0); #1;
      chk("lb_T_stall", {63'd0, stall}, 64'd1);
      chk("lb_T_dmreq", {63'd0, dmreq}, 64'd0);
      step(); idle_in(); #1;
      chk("lb_T1_dmreq", {63'd0, dmreq}, 64'd1);
      chk("lb_dmaddr", dmaddr, 64'h1000);
      chk("lb_dmmask", {56'd0, dmmask}, 64'h08);
      chk("lb_dmwe", {63'd0, dmwe}, 64'd0);
      chk("lb_T1_stall", {63'd0, stall}, 64'd1);
      step(); #1;
      chk("lb_T2_stall", {63'd0, stall}, 64'd1);
      step(); dmack = 1'b1; dmrdata = 64'h0000_0000_8000_0000; #1;
      chk("lb_T3_stall", {63'd0, stall}, 64'd1);
      chk("lb_T3_rvalid", {63'd0, rvalid}, 64'd0);
      step(); dmack = 1'b0; dmrdata = '0; #1;
      chk("lb_T4_rvalid", {63'd0, rvalid}, 64'd1);
      chk("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_T4_stall", {63'd0, stall}, 64'd0);
      chk("lb_T4_dmreq", {63'd0, dmreq}, 64'd0);
      step(); #1;
      chk("lb_T5_rvalid", {63'd0, rvalid}, 64'd0);

      // sw 0x2004, immediate ack
      issue(0, 1, 3'b010, 64'h2004, 64'h0000_0000_DEAD_BEEF); #1;
      chk("sw_T_stall", {63'd0, stall}, 64'd1);
      step(); idle_in(); dmack = 1'b1; #1;
      chk("sw_dmreq", {63'd0, dmreq}, 64'd1);
      chk("sw_dmwe", {63'd0, dmwe}, 64'd1);
      chk("sw_dmaddr", dmaddr, 64'h2000);
      chk("sw_dmmask", {56'd0, dmmask}, 64'hF0);
      chk("sw_dmwdata", dmwdata, 64'hDEAD_BEEF_0000_0000);
      step(); dmack = 1'b0; #1;
      chk("sw_rvalid", {63'd0, rvalid}, 64'd0);
      chk("sw_stall", {63'd0, stall}, 64'd0);
      chk("sw_rdata_kept", rdata, 64'hFFFF_FFFF_FFFF_FF80);
      step();

      // lwu 0x3004
      issue(1, 0, 3'b110, 64'h3004, 64'd0);
      step(); idle_in(); dmack = 1'b1; dmrdata = 64'h8765_4321_0000_0000; #1;
      chk("lwu_dmmask", {56'd0, dmmask}, 64'hF0);
      step(); dmack = 1'b0; #1;
      chk("lwu_rvalid", {63'd0, rvalid}, 64'd1);
      chk("lwu_rdata", rdata, 64'h0000_0000_8765_4321);
      step();

      // lw 0x1002 misaligned
      issue(1, 0, 3'b010, 64'h1002, 64'd0); #1;
      chk("mis_flag", {63'd0, misaligned}, 64'd1);
      chk("mis_badaddr", badaddr, 64'h1002);
      chk("mis_stall", {63'd0, stall}, 64'd0);
      step(); #1;
      chk("mis_dmreq", {63'd0, dmreq}, 64'd0);
      flush = 1'b1; #1;
      chk("mis_flushed", {63'd0, misaligned}, 64'd0);
      chk("mis_flush_stall", {63'd0, stall}, 64'd0);
      idle_in(); #1;
      chk("mis_novalid_flag", {63'd0, misaligned}, 64'd0);
      chk("mis_novalid_bad", badaddr, 64'd0);
      step();

      // ld (funct3 111) killed by flush in first BUSY cycle, ack 3 cycles later
      issue(1, 0, 3'b111, 64'h5000, 64'd0); #1;
      chk("kill_T_stall", {63'd0, stall}, 64'd1);
      step(); idle_in(); flush = 1'b1; #1;
      chk("kill_dmreq1", {63'd0, dmreq}, 64'd1);
      chk("kill_dmmask", {56'd0, dmmask}, 64'hFF);
      step(); flush = 1'b0; #1;
      chk("kill_dmreq2", {63'd0, dmreq}, 64'd1);
      step(); #1;
      chk("kill_dmreq3", {63'd0, dmreq}, 64'd1);
      step(); dmack = 1'b1; dmrdata = 64'hAAAA_BBBB_CCCC_DDDD; #1;
      chk("kill_dmreq_ack", {63'd0, dmreq}, 64'd1);
      chk("kill_stall_ack", {63'd0, stall}, 64'd1);
      // The cycle after ack must be IDLE: a new lh is accepted at once
      step(); dmack = 1'b0; issue(1, 0, 3'b001, 64'h6002, 64'd0); #1;
      chk("kill_rvalid", {63'd0, rvalid}, 64'd0);
      chk("kill_dmreq_off", {63'd0, dmreq}, 64'd0);
      chk("kill_rdata_kept", rdata, 64'h0000_0000_8765_4321);
      chk("kill_idle_accept", {63'd0, stall}, 64'd1);
      step(); idle_in(); dmack = 1'b1; dmrdata = 64'h0000_0000_8001_0000; #1;
      chk("lh_dmmask", {56'd0, dmmask}, 64'h0C);
      step(); dmack = 1'b0; #1;
      chk("lh_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
      step();

      // reset mid-BUSY, then a clean ld at 0x4000
      issue(1, 0, 3'b011, 64'h7000, 64'd0);
      step(); idle_in(); #1;
      chk("rb_dmreq_pre", {63'd0, dmreq}, 64'd1);
      rst_n = 1'b0; #1;
      chk("rb_dmreq", {63'd0, dmreq}, 64'd0);
      chk("rb_stall", {63'd0, stall}, 64'd0);
      chk("rb_dmaddr", dmaddr, 64'd0);
      chk("rb_rdata", rdata, 64'd0);
      step(); #1;
      chk("rb_rvalid", {63'd0, rvalid}, 64'd0);
      rst_n = 1'b1;
      step(); issue(1, 0, 3'b011, 64'h4000, 64'd0); #1;
      chk("ld_T_stall", {63'd0, stall}, 64'd1);
      step(); idle_in(); dmack = 1'b1; dmrdata = 64'h1122_3344_5566_7788; #1;
      chk("ld_dmaddr", dmaddr, 64'h4000);
      step(); dmack = 1'b0; #1;
      chk("ld_rvalid", {63'd0, rvalid}, 64'd1);
      chk("ld_rdata", rdata, 64'h1122_3344_5566_7788);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_mstage.md
# riscv_mstage

Memory-access stage of the RV64IMC pipeline, directly downstream of the execute stage. It consumes the execute-stage result as the effective address and the forwarded rs2 value as store data. It runs a request/acknowledge transaction to the data memory and stalls the pipeline until the access completes. Load data is returned byte-aligned and sign- or zero-extended for write-back.

## Interface
Parameters:
- width, 64, datapath and address width

Ports (name, direction, width, meaning):
- i_riscv_mstage_clk  in  1  clock, rising edge
- i_riscv_mstage_rst  in  1  reset, asynchronous, active-low
- i_riscv_mstage_valid  in  1  valid instruction present in M stage
- i_riscv_mstage_memread  in  1  load
- i_riscv_mstage_memwrite  in  1  store
- i_riscv_mstage_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- i_riscv_mstage_addr  in  width  effective address (execute-stage result)
- i_riscv_mstage_wdata  in  width  store data (forwarded rs2)
- i_riscv_mstage_flush  in  1  kill M-stage instruction
- o_riscv_mstage_dmreq  out  1  memory request
- o_riscv_mstage_dmwe  out  1  1 = write
- o_riscv_mstage_dmaddr  out  width  doubleword-aligned address, bits [2:0] = 0
- o_riscv_mstage_dmwdata  out  width  lane-shifted store data
- o_riscv_mstage_dmmask  out  8  byte enables
- i_riscv_mstage_dmack  in  1  memory acknowledge
- i_riscv_mstage_dmrdata  in  width  memory read data, valid with ack
- o_riscv_mstage_stall  out  1  hold all upstream stages
- o_riscv_mstage_rdata  out  width  extended load result
- o_riscv_mstage_rvalid  out  1  rdata valid, one cycle
- o_riscv_mstage_misaligned  out  1  misaligned access detected
- o_riscv_mstage_badaddr  out  width  faulting address

## Operation
- FSM states: IDLE, BUSY, DONE. Reset enters IDLE.
- start = valid & (memread | memwrite) & ~flush & ~misaligned, evaluated in IDLE only.
- If memread and memwrite are both set, the access is a read.
- funct3 = 111 is treated as 011. For stores, funct3[2] is ignored.
- Misaligned access:
  - Conditions: h with addr[0] ≠ 0; w with addr[1:0] ≠ 0; d with addr[2:0] ≠ 0.
  - In IDLE with valid & (read | write) & ~flush, a misaligned access drives misaligned = 1 and badaddr = addr combinationally.
  - No request is issued and stall stays 0.
- IDLE → BUSY on start. In the start cycle, register:
  - dmaddr = {addr[width-1:3], 3'b000}
  - dmwe = write
  - offset = addr[2:0], funct3
  - dmmask: b = 8'h01 << off; h = 8'h03 << off; w = 8'h0F << off; d = 8'hFF
  - dmwdata = wdata << (8·off)
- BUSY: dmreq = 1, with dmaddr/dmwe/dmwdata/dmmask held stable until dmack. On dmack → DONE.
- Load capture on dmack:
  - s = dmrdata >> (8·offset)
  - rdata = sign- or zero-extend of s[7:0], s[15:0], s[31:0], or s per funct3; store to rdata register.
- DONE: rvalid = 1 for loads, 0 for stores; always → IDLE next cycle. rdata holds its value until the next load capture.
- Flush:
  - In IDLE, flush suppresses start and misaligned.
  - In BUSY, flush does not drop dmreq. The access completes, a "killed" flag is set, and on dmack the FSM returns to IDLE directly: no DONE, no rvalid, rdata not updated.
- stall = (IDLE & start) | BUSY. It is 0 in DONE so the instruction advances at the end of DONE.

## Timing
- Reset values: state IDLE; dmreq, dmwe, dmaddr, dmwdata, dmmask, rdata, rvalid all 0; killed 0. misaligned and badaddr are 0 whenever valid = 0.
- Minimum occupancy is 3 cycles:
  - T: accept, stall = 1
  - T+1: BUSY with dmreq = 1; dmack same cycle
  - T+2: DONE, rvalid = 1, stall = 0
- Each cycle of dmack delay adds one BUSY cycle.
- dmreq is a registered output and never depends combinationally on dmack. The memory may ack in the first req cycle.
- Back-to-back accesses: after DONE, the next access is accepted in the following IDLE cycle. There is at most one request outstanding.
- An asynchronous reset mid-BUSY aborts immediately: dmreq = 0 and no rvalid. The memory side must tolerate the withdrawn request.

## Test plan
- lb, addr 0x1003, dmrdata 0x0000_0000_8000_0000, dmack after 2 BUSY cycles → dmaddr 0x1000, dmmask 0x08; rdata 0xFFFF_FFFF_FFFF_FF80 with rvalid on cycle T+4; stall high T..T+3.
- sw, addr 0x2004, wdata 0x0000_0000_DEAD_BEEF, immediate ack → dmaddr 0x2000, dmwe 1, dmmask 0xF0, dmwdata 0xDEAD_BEEF_0000_0000; rvalid stays 0.
- lwu, addr 0x3004, dmrdata 0x8765_4321_0000_0000 → rdata 0x0000_0000_8765_4321.
- lw, addr 0x1002 → misaligned 1, badaddr 0x1002, dmreq never asserted, stall 0.
- ld accepted, flush in the first BUSY cycle, ack 3 cycles later → dmreq held through ack, no rvalid, rdata unchanged, IDLE on the cycle after ack.
- Reset asserted mid-BUSY → all outputs 0 asynchronously; after release, a new ld at 0x4000 completes normally.
